// File: rtl/flag_branch_unit_pkg.sv
// flag_branch_unit_pkg
//   Shared definitions for the flag register / branch resolver:
//   condition codes, flag bit positions, flag_we encodings, FSM states,
//   the flag struct and the PC-relative target helper.
package flag_branch_unit_pkg;

  // Bit positions inside the 3-bit {V,Z,N} flag vector.
  localparam int FLAG_V = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  // flag_we encodings produced by the ALU decode.
  localparam logic [2:0] FWE_ALL  = 3'b111;  // ADD/SUB
  localparam logic [2:0] FWE_Z    = 3'b010;  // AND/NOR/shifts
  localparam logic [2:0] FWE_NONE = 3'b000;

  typedef enum logic [2:0] {
    BR_NEQ    = 3'b000,
    BR_EQ     = 3'b001,
    BR_GT     = 3'b010,
    BR_LT     = 3'b011,
    BR_GTE    = 3'b100,
    BR_LTE    = 3'b101,
    BR_OVFL   = 3'b110,
    BR_UNCOND = 3'b111
  } br_cond_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } fbu_state_e;

  // Field order matches FLAG_V/FLAG_Z/FLAG_N.
  typedef struct packed {
    logic v;
    logic z;
    logic n;
  } flags_t;

  // PC-relative target: the 9-bit word offset is sign-extended and the
  // sum wraps modulo 2^16.
  function automatic logic [15:0] calcTarget(input logic [15:0] pc,
                                             input logic [8:0]  off);
    return pc + {{7{off[8]}}, off};
  endfunction

endpackage

// File: rtl/flag_branch_unit_if.sv
// flag_branch_unit_if
//   Bundle between the EX stage / front end and flag_branch_unit.
//   master: EX stage side (drives ALU flags, branch request, stall, clear).
//   slave : flag_branch_unit (drives committed flags, branch result,
//           flush/busy and the perf counters).
interface flag_branch_unit_if #(
  parameter int CNT_W = 16
);
  // EX-stage / control inputs to the unit
  logic             stall_in;
  logic             ex_valid;
  logic [2:0]       flag_we;
  logic             alu_v;
  logic             alu_z;
  logic             alu_n;
  logic             br_valid;
  logic [2:0]       br_cond;
  logic [15:0]      br_pc;
  logic [8:0]       br_off;
  logic             cnt_clr;
  // Results from the unit
  logic [2:0]       flags_out;
  logic             br_taken;
  logic [15:0]      br_target;
  logic             flush;
  logic             busy;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] taken_count;

  modport master (
    output stall_in, ex_valid, flag_we, alu_v, alu_z, alu_n,
           br_valid, br_cond, br_pc, br_off, cnt_clr,
    input  flags_out, br_taken, br_target, flush, busy,
           br_count, taken_count
  );

  modport slave (
    input  stall_in, ex_valid, flag_we, alu_v, alu_z, alu_n,
           br_valid, br_cond, br_pc, br_off, cnt_clr,
    output flags_out, br_taken, br_target, flush, busy,
           br_count, taken_count
  );
endinterface

// File: rtl/flag_branch_unit_br_cond_eval.sv
// br_cond_eval
//   Purely combinational condition-code check. Shared with the decode-stage
//   branch predictor check, so it takes already-resolved flags.
//   flags    in  {V,Z,N} flags to test
//   cond     in  3-bit condition code
//   condTrue out branch condition holds
module br_cond_eval
  import flag_branch_unit_pkg::*;
(
  input  flags_t     flags,
  input  logic [2:0] cond,
  output logic       condTrue
);

  always_comb begin
    condTrue = 1'b0;
    case (br_cond_e'(cond))
      BR_NEQ:    condTrue = ~flags.z;
      BR_EQ:     condTrue =  flags.z;
      BR_GT:     condTrue = ~flags.z & ~flags.n;
      BR_LT:     condTrue =  flags.n;
      BR_GTE:    condTrue =  flags.z | ~flags.n;
      BR_LTE:    condTrue =  flags.n |  flags.z;
      BR_OVFL:   condTrue =  flags.v;
      BR_UNCOND: condTrue =  1'b1;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// flag_branch_unit
//   Flag register and branch resolver downstream of the 16-bit ALU.
//   - Masked capture of ALU V/Z/N; committed flags fed back as flags_out.
//   - Branches are resolved on the effective flags (register plus the
//     same-cycle masked write), so a branch right after a flag-setting op
//     needs no stall.
//   - A taken branch emits a one-cycle br_taken with its target and holds
//     flush/busy for FLUSH_CYCLES unstalled cycles (IDLE -> FLUSH -> IDLE).
//   - Saturating branch / taken-branch counters with synchronous clear.
//   Ports:
//     clk    in  rising-edge clock
//     rst_n  in  asynchronous active-low reset
//     bus    slave side of flag_branch_unit_if (see interface for signals)
//   Parameters:
//     FLUSH_CYCLES  flush length after a taken branch, 1..7
//     CNT_W         counter width; must match the interface's CNT_W
module flag_branch_unit
  import flag_branch_unit_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input logic                clk,
  input logic                rst_n,
  flag_branch_unit_if.slave  bus
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  fbu_state_e       state, stateNext;
  logic [2:0]       flushCnt, flushCntNext;
  logic [2:0]       flagReg;
  logic [2:0]       aluFlags;
  logic [2:0]       wrMask;
  logic [2:0]       effFlags;
  logic             flagWrEn;
  logic             condTrue;
  logic             accept;
  logic             take;
  logic             brTaken;
  logic [15:0]      brTarget;
  logic [CNT_W-1:0] brCnt;
  logic [CNT_W-1:0] takenCnt;

  // ---------------------------------------------------------------------
  // Flags with same-cycle bypass. Shadow instructions behind a taken
  // branch are squashed, so writes are gated off in FLUSH.
  // ---------------------------------------------------------------------
  assign aluFlags = {bus.alu_v, bus.alu_z, bus.alu_n};
  assign flagWrEn = bus.ex_valid & ~bus.stall_in & (state == ST_IDLE);
  assign wrMask   = flagWrEn ? bus.flag_we : FWE_NONE;
  assign effFlags = (flagReg & ~wrMask) | (aluFlags & wrMask);

  br_cond_eval uCondEval (
    .flags    (flags_t'(effFlags)),
    .cond     (bus.br_cond),
    .condTrue (condTrue)
  );

  // ---------------------------------------------------------------------
  // FSM: next state / flush counter
  // ---------------------------------------------------------------------
  always_comb begin
    stateNext    = state;
    flushCntNext = flushCnt;
    accept       = 1'b0;
    take         = 1'b0;
    case (state)
      ST_IDLE: begin
        accept = bus.br_valid & ~bus.stall_in;
        take   = accept & condTrue;
        if (take) begin
          stateNext    = ST_FLUSH;
          flushCntNext = FLUSH_LOAD;
        end
      end
      ST_FLUSH: begin
        // br_valid is ignored here: those branches are in the shadow.
        if (!bus.stall_in) begin
          flushCntNext = flushCnt - 3'd1;
          if (flushCnt == 3'd1) stateNext = ST_IDLE;
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      flushCnt <= '0;
    end else begin
      state    <= stateNext;
      flushCnt <= flushCntNext;
    end
  end

  // ---------------------------------------------------------------------
  // Flag register and branch result. br_taken is rewritten every edge,
  // so a stall can never stretch the pulse.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flagReg  <= '0;
      brTaken  <= 1'b0;
      brTarget <= '0;
    end else begin
      flagReg <= effFlags;
      brTaken <= take;
      if (take) brTarget <= calcTarget(bus.br_pc, bus.br_off);
    end
  end

  // ---------------------------------------------------------------------
  // Saturating perf counters; clear wins and works through a stall.
  // accept/take already exclude stalled cycles.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brCnt    <= '0;
      takenCnt <= '0;
    end else if (bus.cnt_clr) begin
      brCnt    <= '0;
      takenCnt <= '0;
    end else begin
      if (accept && brCnt != '1)   brCnt    <= brCnt + 1'b1;
      if (take && takenCnt != '1)  takenCnt <= takenCnt + 1'b1;
    end
  end

  assign bus.flags_out   = flagReg;
  assign bus.br_taken    = brTaken;
  assign bus.br_target   = brTarget;
  assign bus.flush       = (state == ST_FLUSH);
  assign bus.busy        = (state == ST_FLUSH);
  assign bus.br_count    = brCnt;
  assign bus.taken_count = takenCnt;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Scoreboard bench for flag_branch_unit. The driver advances a behavioural
// model one cycle per stimulus and queues the expected post-edge outputs;
// a monitor on the falling edge pops and compares. Taken-branch targets go
// through their own queue, popped whenever the DUT pulses br_taken.
// A narrow counter width is used so saturation is reachable quickly.
module tb_flag_branch_unit;

  localparam int CNT_W   = 8;
  localparam int FLUSH_N = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    bit          stall;
    bit          exv;
    logic [2:0]  we;
    bit          v, z, n;
    bit          brv;
    logic [2:0]  cond;
    logic [15:0] pc;
    logic [8:0]  off;
    bit          clr;
  } stim_t;

  typedef struct {
    logic [2:0]  flags;
    bit          taken;
    logic [15:0] target;
    bit          flush;
    int          brc;
    int          tkc;
  } exp_t;

  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;

  flag_branch_unit_if #(.CNT_W(CNT_W)) bus ();

  flag_branch_unit #(.FLUSH_CYCLES(FLUSH_N), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  exp_t        stQ[$];
  logic [15:0] tgtQ[$];

  // Model state: what the DUT's outputs should show right now.
  logic [2:0]  mFlags;
  int          mFlushLeft;
  int          mBr, mTk;
  bit          mTaken;
  logic [15:0] mTarget;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit condHolds(input logic [2:0] f, input logic [2:0] c);
    bit v = f[2], z = f[1], n = f[0];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic stim_t idleStim();
    stim_t s;
    s.stall = 0; s.exv = 0; s.we = 3'b000; s.v = 0; s.z = 0; s.n = 0;
    s.brv = 0; s.cond = 3'd0; s.pc = 16'h0; s.off = 9'h0; s.clr = 0;
    return s;
  endfunction

  function automatic stim_t brStim(input logic [2:0] c, input logic [15:0] pc,
                                   input logic [8:0] off);
    stim_t s = idleStim();
    s.brv = 1; s.cond = c; s.pc = pc; s.off = off;
    return s;
  endfunction

  function automatic stim_t wrStim(input logic [2:0] we, input bit v,
                                   input bit z, input bit n);
    stim_t s = idleStim();
    s.exv = 1; s.we = we; s.v = v; s.z = z; s.n = n;
    return s;
  endfunction

  function automatic stim_t randStim();
    stim_t s;
    s.stall = ($urandom % 6) == 0;
    s.exv   = $urandom % 2;
    case ($urandom % 4)
      0: s.we = 3'b111;
      1: s.we = 3'b010;
      2: s.we = 3'b000;
      default: s.we = 3'($urandom);
    endcase
    s.v = $urandom % 2; s.z = $urandom % 2; s.n = $urandom % 2;
    s.brv  = $urandom % 2;
    s.cond = 3'($urandom);
    s.pc   = 16'($urandom);
    s.off  = 9'($urandom);
    s.clr  = ($urandom % 400) == 0;
    return s;
  endfunction

  task automatic modelReset();
    mFlags = 0; mFlushLeft = 0; mBr = 0; mTk = 0; mTaken = 0; mTarget = 0;
  endtask

  task automatic applyStim(input stim_t s);
    bus.stall_in = s.stall; bus.ex_valid = s.exv; bus.flag_we = s.we;
    bus.alu_v = s.v; bus.alu_z = s.z; bus.alu_n = s.n;
    bus.br_valid = s.brv; bus.br_cond = s.cond; bus.br_pc = s.pc;
    bus.br_off = s.off; bus.cnt_clr = s.clr;
  endtask

  // One clock: drive, predict, cross the edge, publish the prediction.
  task automatic cycle(input stim_t s);
    logic [2:0] eff;
    bit idle, accept, take;
    int off, nFlush, nBr, nTk;
    exp_t e;
    applyStim(s);
    idle = (mFlushLeft == 0);
    eff  = mFlags;
    if (s.exv && !s.stall && idle)
      for (int i = 0; i < 3; i++) if (s.we[i]) eff[i] = (i == 2) ? s.v : (i == 1) ? s.z : s.n;
    accept = idle && s.brv && !s.stall;
    take   = accept && condHolds(eff, s.cond);
    nFlush = mFlushLeft;
    if (take) nFlush = FLUSH_N;
    else if (mFlushLeft > 0 && !s.stall) nFlush = mFlushLeft - 1;
    nBr = mBr; nTk = mTk;
    if (s.clr) begin nBr = 0; nTk = 0; end
    else begin
      if (accept && nBr < CNT_MAX) nBr++;
      if (take && nTk < CNT_MAX) nTk++;
    end
    if (take) begin
      off = s.off[8] ? int'(s.off) - 512 : int'(s.off);
      mTarget = 16'((int'(s.pc) + off) & 32'hFFFF);
      tgtQ.push_back(mTarget);
    end
    @(posedge clk);
    mFlags = eff; mFlushLeft = nFlush; mBr = nBr; mTk = nTk; mTaken = take;
    e.flags = mFlags; e.taken = mTaken; e.target = mTarget;
    e.flush = (mFlushLeft > 0); e.brc = mBr; e.tkc = mTk;
    stQ.push_back(e);
    #1;
  endtask

  task automatic repeatStim(input stim_t s, input int n);
    for (int i = 0; i < n; i++) cycle(s);
  endtask

  // Monitor: compare after every edge's prediction arrives.
  always @(negedge clk) begin
    if (rst_n && stQ.size() > 0) begin
      exp_t e;
      e = stQ.pop_front();
      chk("flags_out",   int'(bus.flags_out),   int'(e.flags));
      chk("br_taken",    int'(bus.br_taken),    int'(e.taken));
      chk("br_target",   int'(bus.br_target),   int'(e.target));
      chk("flush",       int'(bus.flush),       int'(e.flush));
      chk("busy",        int'(bus.busy),        int'(e.flush));
      chk("br_count",    int'(bus.br_count),    e.brc);
      chk("taken_count", int'(bus.taken_count), e.tkc);
    end
    if (rst_n && bus.br_taken) begin
      if (tgtQ.size() == 0) chk("unexpected br_taken", 1, 0);
      else chk("taken target", int'(bus.br_target), int'(tgtQ.pop_front()));
    end
  end

  task automatic checkResetOutputs(input string tag);
    chk({tag, " flags_out"},   int'(bus.flags_out),   0);
    chk({tag, " br_taken"},    int'(bus.br_taken),    0);
    chk({tag, " br_target"},   int'(bus.br_target),   0);
    chk({tag, " flush"},       int'(bus.flush),       0);
    chk({tag, " busy"},        int'(bus.busy),        0);
    chk({tag, " br_count"},    int'(bus.br_count),    0);
    chk({tag, " taken_count"}, int'(bus.taken_count), 0);
  endtask

  // Asynchronous reset asserted between edges, checked before any edge.
  task automatic resetPulse();
    @(negedge clk);
    #1;
    applyStim(idleStim());
    rst_n = 0;
    #1;
    checkResetOutputs("mid reset");
    modelReset();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    stim_t s;
    applyStim(idleStim());
    modelReset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetOutputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1;

    // EQ branch after flag-setting op: target 0x0015, 2-cycle flush.
    cycle(wrStim(3'b111, 0, 1, 0));
    cycle(brStim(3'd1, 16'h0010, 9'd5));
    repeat (3) cycle(idleStim());

    // Bypass: flags cleared, then Z write and EQ branch in the same cycle.
    cycle(wrStim(3'b111, 0, 0, 0));
    s = wrStim(3'b010, 0, 1, 0);
    s.brv = 1; s.cond = 3'd1; s.pc = 16'h1234; s.off = 9'h010;
    cycle(s);
    repeat (3) cycle(idleStim());

    // Mask: V set, then Z-only write leaves V, then OVFL taken.
    cycle(wrStim(3'b111, 1, 0, 0));
    cycle(wrStim(3'b010, 0, 0, 1));
    cycle(brStim(3'd6, 16'h0100, 9'h0FF));
    repeat (3) cycle(idleStim());

    // Wrap below zero.
    cycle(brStim(3'd7, 16'h0002, 9'h1FC));
    repeat (3) cycle(idleStim());

    // Branches and flag writes in the flush shadow are squashed.
    cycle(brStim(3'd7, 16'h4000, 9'h020));
    s = brStim(3'd7, 16'h5000, 9'h001);
    s.exv = 1; s.we = 3'b111; s.v = 1; s.z = 1; s.n = 1;
    repeat (2) cycle(s);
    repeat (2) cycle(idleStim());

    // Stall during flush extends it; a stalled branch is not accepted.
    cycle(brStim(3'd7, 16'h6000, 9'h003));
    s = brStim(3'd7, 16'h7000, 9'h004);
    s.stall = 1;
    repeat (3) cycle(s);
    repeat (3) cycle(idleStim());
    repeat (2) cycle(s);
    cycle(idleStim());

    // Reset in the middle of a flush.
    cycle(brStim(3'd7, 16'h8000, 9'h005));
    resetPulse();
    cycle(idleStim());

    // Counter saturation: not-taken NEQ with Z=1, then back-to-back UNCOND.
    cycle(wrStim(3'b111, 0, 1, 0));
    repeat (300) cycle(brStim(3'd0, 16'h0000, 9'h000));
    repeat (800) cycle(brStim(3'd7, 16'h2222, 9'h011));
    // Clear beats an increment, and works during stall.
    s = brStim(3'd7, 16'h3333, 9'h000);
    s.clr = 1;
    cycle(idleStim()); cycle(idleStim()); cycle(idleStim());
    cycle(s);
    repeat (3) cycle(idleStim());
    repeat (20) cycle(brStim(3'd0, 16'h0, 9'h0));
    s = idleStim(); s.stall = 1; s.clr = 1;
    cycle(s);

    // Randomized traffic.
    repeat (3000) cycle(randStim());
    repeat (4) cycle(idleStim());

    @(negedge clk);
    #1;
    chk("status queue drained", stQ.size(), 0);
    chk("target queue drained", tgtQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety net in case the run stops making progress.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/flag_branch_unit.md
Name: flag_branch_unit

Overview:
- Stateful flag register and branch resolver sitting directly downstream of the 16-bit saturating ALU.
- Captures the ALU's V/Z/N outputs under a per-bit write mask and drives the committed flags back to the ALU's 3-bit flags input, ordered {V,Z,N}.
- Resolves conditional branches against the flags (same-cycle bypass included), computes the PC-relative target and produces a timed flush pulse for the front end.
- Keeps saturating branch and taken-branch counters for performance debug.

Parameters:
- FLUSH_CYCLES, 2, cycles `flush` stays high after a taken branch; legal range 1..7.
- CNT_W, 16, width of the branch and taken-branch counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall_in  in  1  pipeline stall; freezes all state updates.
- ex_valid  in  1  EX-stage instruction valid this cycle.
- flag_we  in  3  per-bit flag write mask {V,Z,N}; ADD/SUB drive 111, AND/NOR/shifts drive 010, others 000.
- alu_v  in  1  ALU overflow flag.
- alu_z  in  1  ALU zero flag.
- alu_n  in  1  ALU negative flag.
- br_valid  in  1  branch instruction present for resolution.
- br_cond  in  3  condition code.
- br_pc  in  16  PC of the instruction following the branch.
- br_off  in  9  signed word offset.
- flags_out  out  3  committed flags {V,Z,N}; feeds the ALU flags input.
- br_taken  out  1  one-cycle pulse, registered.
- br_target  out  16  registered target; valid while br_taken=1.
- flush  out  1  squash younger instructions.
- busy  out  1  high while in FLUSH state.
- cnt_clr  in  1  synchronous clear of both counters.
- br_count  out  CNT_W  branches resolved.
- taken_count  out  CNT_W  branches taken.

Behaviour:
Reset:
- All outputs 0: flags_out=000, br_taken=0, br_target=0000, flush=0, busy=0, counters 0.
- State is IDLE.
- Reset is asynchronous; asserting it mid-FLUSH aborts the flush immediately.

Flags:
- Bit i of the flag register updates on a clock edge when ex_valid & flag_we[i] & ~stall_in & ~flush.
- Bits with flag_we[i]=0 hold their value.
- Effective flags (eff) = register value with the same-cycle masked update merged in whenever that update condition is true. This is the bypass: a branch sees the result of the immediately preceding flag-setting instruction with no stall.

Condition codes (evaluated on eff):
- 000 NEQ: Z=0
- 001 EQ: Z=1
- 010 GT: Z=0 and N=0
- 011 LT: N=1
- 100 GTE: Z=1 or N=0
- 101 LTE: N=1 or Z=1
- 110 OVFL: V=1
- 111 UNCOND: always

FSM states: IDLE, FLUSH.
- IDLE: a branch is accepted when br_valid & ~stall_in.
  - On the next edge: br_count increments.
  - If the condition is true: br_taken=1 for one cycle; br_target = br_pc + sign_extend(br_off) mod 2^16; taken_count increments; load the flush counter with FLUSH_CYCLES; go to FLUSH.
  - If the condition is false: br_taken=0; br_target holds; stay in IDLE.
- FLUSH: flush=1 and busy=1, asserted in the same cycle as the br_taken pulse.
  - The counter decrements on each edge where ~stall_in, and holds while stalled.
  - On reaching 0, return to IDLE; flush deasserts on that edge.
  - br_valid is ignored (squashed, not counted).
  - Flag writes are suppressed (the shadow instructions are squashed).

Latency:
- Branch resolution: 1 cycle from acceptance to br_taken.
- Back-to-back not-taken branches are accepted every cycle.

Counters:
- Saturate at all-ones and do not wrap.
- cnt_clr beats an increment in the same cycle.
- cnt_clr is honoured during stall_in.

Simultaneous events:
- Branch and flag write in the same IDLE cycle: the branch uses eff, and the register updates.
- stall_in blocks acceptance, flag writes and counter increments. br_taken is still a single pulse and is never stretched by a stall.

Decomposition:
- Shared package/defines holds:
  - condition-code constants (BR_NEQ..BR_UNCOND);
  - flag bit indices FLAG_V=2, FLAG_Z=1, FLAG_N=0;
  - flag_we encodings (FWE_ALL=111, FWE_Z=010, FWE_NONE=000);
  - FSM state encodings.
- One sub-module, br_cond_eval: combinational (eff flags, br_cond) -> cond_true. It is reused by the decode-stage branch predictor check.

Test Plan:
- Reset: hold rst_n=0 then release -> flags_out=000, br_taken=0, flush=0, br_count=0, br_target=0000.
- ex_valid, flag_we=111, V/Z/N=0/1/0, then next cycle br EQ with br_pc=0x0010, br_off=+5 -> br_taken pulse, br_target=0x0015, flush high exactly 2 cycles, taken_count=1.
- Bypass: flags register=000; same cycle ex_valid, flag_we=010, alu_z=1, plus br EQ -> taken; flags_out becomes 010.
- Mask: V set to 1 earlier; flag_we=010, alu_z=0, then br OVFL -> flags_out=100, br taken.
- Wrap: br UNCOND, br_pc=0x0002, br_off=9'h1FC (-4) -> br_target=0xFFFE.
- Flush shadow:
  - br_valid during FLUSH -> ignored, br_count unchanged.
  - stall_in during FLUSH -> flush extended by the stall length.
  - rst_n pulse mid-FLUSH -> flush=0 immediately, state IDLE.
  - Preload counters near FFFF -> saturate at FFFF.
